// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// One valid/ready link between two pipeline stages. It carries a PC, an
// instruction and a sideband field.
//
// Signals:
//   valid  driven by master : entry on pc/inst/side is valid
//   ready  driven by slave  : receiver can take the entry this cycle
//   pc     driven by master : program counter            [PC_W]
//   inst   driven by master : instruction word           [INST_W]
//   side   driven by master : decode hints / exceptions  [SIDE_W]
//
// Modports:
//   master : the side that produces entries (drives valid/pc/inst/side)
//   slave  : the side that consumes entries (drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int SIDE_W = 8
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic [SIDE_W-1:0] side;

  modport master (output valid, output pc, output inst, output side, input ready);
  modport slave  (input valid, input pc, input inst, input side, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Parametrised pipeline-stage register with a valid/ready handshake. It
// replaces a fixed stage latch driven by a global stall vector. With SKID=1
// a second (skid) register absorbs the one extra entry that arrives while
// backpressure propagates. This lets up.ready be a plain flop, which cuts
// the ready timing path at every stage. With SKID=0 the stage is a single
// register and up.ready is combinational.
//
// Parameters:
//   PC_W, INST_W, SIDE_W : field widths (SIDE_W >= 1)
//   NOP_INST             : instruction shown on dn.inst while dn.valid=0
//   SKID                 : 1 = two-entry skid buffer, 0 = single register
//   CNT_W                : width of the saturating bubble counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   discard every held entry at the next edge
//   up         in   slave side of the upstream link (up.ready is an output)
//   dn         out  master side of the downstream link (dn.ready is an input)
//   bubble_cnt out  cycles with dn.ready=1 and dn.valid=0, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int          PC_W     = 32,
  parameter int          INST_W   = 32,
  parameter int          SIDE_W   = 8,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          SKID     = 1,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  pipe_stage_skid_if.slave     up,
  pipe_stage_skid_if.master    dn,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // NOP_INST is truncated or zero-extended to the instruction width.
  localparam logic [INST_W-1:0] NOP_I = INST_W'(NOP_INST);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   main_pc,   skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic [SIDE_W-1:0] main_side, skid_side;
  logic              up_ready_q;
  logic              dn_valid;
  logic              up_ready;
  logic              accept;
  logic              drain;

  // The downstream side is driven only from registers. No up.* input
  // reaches dn.* combinationally.
  assign dn_valid  = (state != EMPTY);
  assign dn.valid  = dn_valid;
  assign dn.pc     = main_pc;
  assign dn.inst   = main_inst;
  assign dn.side   = main_side;

  // With the skid buffer, ready is a flop that falls only when both
  // entries are occupied. Without it, ready is computed from the current
  // occupancy and dn.ready.
  assign up_ready  = (SKID != 0) ? up_ready_q : (!dn_valid || dn.ready);
  assign up.ready  = up_ready;

  assign accept    = up.valid && up_ready;
  assign drain     = dn_valid && dn.ready;

  // Occupancy FSM, data registers and bubble counter.
  // Flush wins over every transition. A handshake in the flush cycle still
  // completes on both sides: the downstream entry counts as consumed and
  // the upstream entry is simply not stored. The bubble counter does not
  // depend on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_inst  <= NOP_I;
      main_side  <= '0;
      skid_pc    <= '0;
      skid_inst  <= NOP_I;
      skid_side  <= '0;
      up_ready_q <= 1'b1;
      bubble_cnt <= '0;
    end else begin
      if (dn.ready && !dn_valid && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end

      if (flush) begin
        state      <= EMPTY;
        main_pc    <= '0;
        main_inst  <= NOP_I;
        main_side  <= '0;
        skid_pc    <= '0;
        skid_inst  <= NOP_I;
        skid_side  <= '0;
        up_ready_q <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= ONE;
              main_pc   <= up.pc;
              main_inst <= up.inst;
              main_side <= up.side;
            end
          end

          ONE: begin
            // The first branch is only reachable with SKID=1. With SKID=0,
            // an accept while ONE implies dn.ready, and so also a drain.
            if (accept && !drain && (SKID != 0)) begin
              state      <= TWO;
              skid_pc    <= up.pc;
              skid_inst  <= up.inst;
              skid_side  <= up.side;
              up_ready_q <= 1'b0;
            end else if (accept) begin
              main_pc   <= up.pc;
              main_inst <= up.inst;
              main_side <= up.side;
            end else if (drain) begin
              state     <= EMPTY;
              main_pc   <= '0;
              main_inst <= NOP_I;
              main_side <= '0;
            end
          end

          TWO: begin
            // The older entry leaves, and the skid entry moves up to main.
            if (drain) begin
              state      <= ONE;
              main_pc    <= skid_pc;
              main_inst  <= skid_inst;
              main_side  <= skid_side;
              skid_pc    <= '0;
              skid_inst  <= NOP_I;
              skid_side  <= '0;
              up_ready_q <= 1'b1;
            end
          end

          default: begin
            state      <= EMPTY;
            up_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
